spi_slave_engine: RTL

SPI responder (slave) engine for the processor's SPI peripheral slot: the far end of the SPI master engine, letting the PLC core act as a device on an external SPI bus. It oversamples the bus on the system clock, shifts 8-bit frames MSB-first, and exposes a one-deep transmit buffer and a one-deep receive buffer with ready and overrun flags. The control unit drives it through read and write strobes; the accumulator MUX reads its status and data.

---
 rtl/spi_slave_engine_pkg.sv | 15 +
 rtl/spi_slave_engine_if.sv | 21 ++
 rtl/spi_slave_engine_sync_edge.sv | 34 +++
 rtl/spi_slave_engine.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/spi_slave_engine_pkg.sv
// Shared types and constants for the SPI responder engine.
package spi_slave_engine_pkg;
  localparam int         DATA_W_DEF = 8;
  localparam logic [7:0] IDLE_FILL  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/spi_slave_engine_if.sv
// Pin and host-side bundle of the SPI responder; cpol/cpha exist only with SPI_SLAVE_MODE_SEL_EN.
interface spi_slave_engine_if #(parameter int DATA_W = 8);
  logic              ssN, sck, mosi, miso, misoOe;
`ifdef SPI_SLAVE_MODE_SEL_EN
  logic              cpol, cpha;
`endif
  logic [DATA_W-1:0] txData, rxData;
  logic              txWrite, txFull, rxRead, rxReady, overrun, busy;

`ifdef SPI_SLAVE_MODE_SEL_EN
  modport slave  (input  ssN, sck, mosi, cpol, cpha, txData, txWrite, rxRead,
                  output miso, misoOe, txFull, rxData, rxReady, overrun, busy);
  modport master (output ssN, sck, mosi, cpol, cpha, txData, txWrite, rxRead,
                  input  miso, misoOe, txFull, rxData, rxReady, overrun, busy);
`else
  modport slave  (input  ssN, sck, mosi, txData, txWrite, rxRead,
                  output miso, misoOe, txFull, rxData, rxReady, overrun, busy);
  modport master (output ssN, sck, mosi, txData, txWrite, rxRead,
                  input  miso, misoOe, txFull, rxData, rxReady, overrun, busy);
`endif
endinterface

// File: rtl/spi_slave_engine_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, plus rise/fall pulses on the synced level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;
endmodule

// File: rtl/spi_slave_engine.sv
// SPI responder: oversampled bus, MSB-first frames, one-deep tx/rx buffers.
// SPI_SLAVE_MODE_SEL_EN adds runtime cpol/cpha; otherwise fixed to mode 0.
module spi_slave_engine
  import spi_slave_engine_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset,
  spi_slave_engine_if.slave bus
);
  localparam int                CW   = cnt_w(DATA_W);
  localparam logic [CW-1:0]     LAST = CW'(DATA_W - 1);
  localparam logic [DATA_W-1:0] FILL = {DATA_W{IDLE_FILL[0]}};

  logic ssn_s, ssn_rise, ssn_fall;
  logic sck_s_unused, sck_rise, sck_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssn (
    .clk(clk), .reset(reset), .d(bus.ssN), .q(ssn_s), .rise(ssn_rise), .fall(ssn_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .d(bus.sck), .q(sck_s_unused), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .d(bus.mosi), .q(mosi_s), .rise(mosi_rise_unused),
    .fall(mosi_fall_unused));

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              miso_q, miso_d, tx_full_q, tx_full_d;
  logic              rx_ready_q, rx_ready_d, ovr_q, ovr_d;
  logic              cpol, cpha;

`ifdef SPI_SLAVE_MODE_SEL_EN
  // Mode is latched only while idle so a frame never sees it change.
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  always_comb begin
    cpol_d = (state_q == ST_IDLE) ? bus.cpol : cpol_q;
    cpha_d = (state_q == ST_IDLE) ? bus.cpha : cpha_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else begin
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
    end
  end
  assign cpol = cpol_q;
  assign cpha = cpha_q;
`else
  assign cpol = 1'b0;
  assign cpha = 1'b0;
`endif

  logic lead_e, trail_e, sample_e, shift_e, load;
  logic [DATA_W-1:0] rx_byte, load_val;

  assign lead_e   = cpol ? sck_fall : sck_rise;
  assign trail_e  = cpol ? sck_rise : sck_fall;
  assign sample_e = cpha ? trail_e : lead_e;
  assign shift_e  = cpha ? lead_e : trail_e;
  assign rx_byte  = {shift_q[DATA_W-2:0], mosi_s};
  assign load_val = tx_full_q ? tx_buf_q : FILL;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ssn_fall) state_d = ST_LOAD;
      ST_LOAD:  state_d = ssn_rise ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (ssn_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    miso_d     = miso_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = rx_ready_q;
    ovr_d      = ovr_q;
    load       = 1'b0;

    if (bus.rxRead && rx_ready_q) begin
      rx_ready_d = 1'b0;
      ovr_d      = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        miso_d = 1'b1;
        if (ssn_fall) begin
          load   = 1'b1;
          miso_d = load_val[DATA_W-1];
        end
      end
      ST_LOAD: if (ssn_rise) cnt_d = '0;
      ST_SHIFT: begin
        if (ssn_rise) begin
          cnt_d = '0;
        end else begin
          if (sample_e) begin
            shift_d = rx_byte;
            if (cnt_q == LAST) begin
              cnt_d = '0;
              load  = 1'b1;
              if (!rx_ready_q || bus.rxRead) begin
                rx_data_d  = rx_byte;
                rx_ready_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          // After a sample the MSB already holds the next outgoing bit.
          if (shift_e) miso_d = shift_q[DATA_W-1];
        end
      end
      default: cnt_d = '0;
    endcase

    if (load) begin
      shift_d   = load_val;
      tx_full_d = 1'b0;
    end
    // A write in the same cycle as a load from an empty buffer lands after it.
    if (bus.txWrite && !tx_full_q) begin
      tx_buf_d  = bus.txData;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b1;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.miso    = miso_q;
  assign bus.misoOe  = ~ssn_s;
  assign bus.txFull  = tx_full_q;
  assign bus.rxData  = rx_data_q;
  assign bus.rxReady = rx_ready_q;
  assign bus.overrun = ovr_q;
  assign bus.busy    = ~ssn_s & (cnt_q != '0);
endmodule
